// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared widths, reset defaults and the configuration record for
// the programmable DPWM.
//   CNT_W   counter / period / on-time width
//   DT_W    dead-time field width
//   DEF_*   configuration loaded at reset
//   MIN_TS  smallest legal period
//   dpwm_cfg_t  {ts, ton, dt1, dt2}
package dpwm_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned DT_W    = 4;
    localparam int unsigned DEF_TS  = 140;
    localparam int unsigned DEF_TON = 80;
    localparam int unsigned DEF_DT1 = 14;
    localparam int unsigned DEF_DT2 = 10;
    localparam int unsigned MIN_TS  = 2;

    typedef struct packed {
        logic [CNT_W-1:0] ts;
        logic [CNT_W-1:0] ton;
        logic [DT_W-1:0]  dt1;
        logic [DT_W-1:0]  dt2;
    } dpwm_cfg_t;

endpackage

// File: rtl/dpwm_cfg_shadow.sv
// dpwm_cfg_shadow: double-buffered DPWM configuration.
//   i_clk, reset_n   clock, asynchronous active-low reset
//   i_load           one-cycle strobe capturing i_req
//   i_last           current cycle is the last of the period
//   i_req            requested configuration
//   o_active         configuration governing the current period
//   o_active_nxt     configuration that will be active next cycle
//   o_pending        a loaded set is waiting for the boundary
//   o_clamped        the active set was altered by the clamp
module dpwm_cfg_shadow
    import dpwm_pkg::*;
#(
    parameter int unsigned DEF_TS  = dpwm_pkg::DEF_TS,
    parameter int unsigned DEF_TON = dpwm_pkg::DEF_TON,
    parameter int unsigned DEF_DT1 = dpwm_pkg::DEF_DT1,
    parameter int unsigned DEF_DT2 = dpwm_pkg::DEF_DT2,
    parameter int unsigned MIN_TS  = dpwm_pkg::MIN_TS
) (
    input  logic      i_clk,
    input  logic      reset_n,
    input  logic      i_load,
    input  logic      i_last,
    input  dpwm_cfg_t i_req,
    output dpwm_cfg_t o_active,
    output dpwm_cfg_t o_active_nxt,
    output logic      o_pending,
    output logic      o_clamped
);

    localparam int unsigned      SW       = CNT_W + 2;
    localparam logic [CNT_W-1:0] MIN_TS_V = CNT_W'(MIN_TS);
    localparam dpwm_cfg_t        DEF_CFG  = '{ts:  CNT_W'(DEF_TS),
                                              ton: CNT_W'(DEF_TON),
                                              dt1: DT_W'(DEF_DT1),
                                              dt2: DT_W'(DEF_DT2)};

    dpwm_cfg_t     pend_q;
    dpwm_cfg_t     active_q;
    dpwm_cfg_t     src;
    dpwm_cfg_t     fixed;
    logic          pend_vld_q;
    logic          clamped_q;
    logic          copy;
    logic          altered;
    logic [SW-1:0] ts_w;
    logic [SW-1:0] dts_w;
    logic [SW-1:0] need_w;

    // A load on the last cycle bypasses the pending register, so the clamp
    // always sees whichever set is about to become active.
    always_comb begin
        src   = (i_load && i_last) ? i_req : pend_q;
        fixed = src;
        if (src.ts < MIN_TS_V) begin
            fixed.ts = MIN_TS_V;
        end
        ts_w   = {2'b00, fixed.ts};
        dts_w  = SW'(src.dt1) + SW'(src.dt2);
        need_w = dts_w + {2'b00, src.ton};
        if (need_w > ts_w) begin
            fixed.ton = (dts_w >= ts_w) ? '0 : CNT_W'(ts_w - dts_w);
        end
        altered = (fixed.ts != src.ts) || (fixed.ton != src.ton);
    end

    assign copy         = i_last && (i_load || pend_vld_q);
    assign o_active_nxt = copy ? fixed : active_q;
    assign o_active     = active_q;
    assign o_pending    = pend_vld_q;
    assign o_clamped    = clamped_q;

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            active_q   <= DEF_CFG;
            clamped_q  <= 1'b0;
        end else begin
            active_q <= o_active_nxt;
            if (copy) begin
                clamped_q <= altered;
            end
            if (i_last) begin
                pend_vld_q <= 1'b0;
            end else if (i_load) begin
                pend_q     <= i_req;
                pend_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpwm_prog.sv
// dpwm_prog: run-time programmable DPWM for a half-bridge.
//   i_clk, reset_n        clock, asynchronous active-low reset
//   enable                output enable level
//   i_load                strobe capturing i_ts/i_ton/i_dt1/i_dt2
//   i_ts, i_ton           requested period and c1 on-time
//   i_dt1, i_dt2          dead times before / after c1
//   o_count               counter value (aligned with c1/c2)
//   o_cntrl_ts_last       count == ts-1
//   o_pending, o_clamped  shadow-register status
//   c1, c2                high-side / low-side gates
module dpwm_prog
    import dpwm_pkg::*;
#(
    parameter int unsigned CNT_W   = dpwm_pkg::CNT_W,
    parameter int unsigned DT_W    = dpwm_pkg::DT_W,
    parameter int unsigned DEF_TS  = dpwm_pkg::DEF_TS,
    parameter int unsigned DEF_TON = dpwm_pkg::DEF_TON,
    parameter int unsigned DEF_DT1 = dpwm_pkg::DEF_DT1,
    parameter int unsigned DEF_DT2 = dpwm_pkg::DEF_DT2,
    parameter int unsigned MIN_TS  = dpwm_pkg::MIN_TS
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_ts,
    input  logic [CNT_W-1:0] i_ton,
    input  logic [DT_W-1:0]  i_dt1,
    input  logic [DT_W-1:0]  i_dt2,
    output logic [CNT_W-1:0] o_count,
    output logic             o_cntrl_ts_last,
    output logic             o_pending,
    output logic             o_clamped,
    output logic             c1,
    output logic             c2
);

    localparam int unsigned SW = CNT_W + 2;

    dpwm_cfg_t        req;
    dpwm_cfg_t        act;
    dpwm_cfg_t        act_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] next_count;
    logic             en_q;
    logic             en_gate;
    logic             ts_last;
    logic             c1_q;
    logic             c2_q;
    logic             c1_d;
    logic             c2_d;
    logic [SW-1:0]    nc_w;
    logic [SW-1:0]    on_start;
    logic [SW-1:0]    on_end;
    logic [SW-1:0]    off_start;

    assign req = '{ts: i_ts, ton: i_ton, dt1: i_dt1, dt2: i_dt2};

    dpwm_cfg_shadow #(
        .DEF_TS  (DEF_TS),
        .DEF_TON (DEF_TON),
        .DEF_DT1 (DEF_DT1),
        .DEF_DT2 (DEF_DT2),
        .MIN_TS  (MIN_TS)
    ) u_shadow (
        .i_clk        (i_clk),
        .reset_n      (reset_n),
        .i_load       (i_load),
        .i_last       (ts_last),
        .i_req        (req),
        .o_active     (act),
        .o_active_nxt (act_nxt),
        .o_pending    (o_pending),
        .o_clamped    (o_clamped)
    );

    assign ts_last = (count_q == (act.ts - CNT_W'(1)));

    // Gates are decoded from next_count with the configuration that will be
    // active then, so a new set applies from count 0 with no stale cycle.
    // A rising enable only counts at the wrap, so the first pulse is whole.
    always_comb begin
        next_count = ts_last ? '0 : count_q + CNT_W'(1);
        en_gate    = en_q || (enable && ts_last);
        nc_w       = {2'b00, next_count};
        on_start   = SW'(act_nxt.dt1);
        on_end     = on_start + {2'b00, act_nxt.ton};
        off_start  = on_end + SW'(act_nxt.dt2);
        c1_d       = en_gate && (nc_w >= on_start) && (nc_w < on_end);
        c2_d       = en_gate && (nc_w >= off_start) && (next_count < act_nxt.ts);
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            en_q    <= 1'b0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
        end else begin
            count_q <= next_count;
            en_q    <= enable && (en_q || ts_last);
            c1_q    <= c1_d;
            c2_q    <= c2_d;
        end
    end

    assign o_count         = count_q;
    assign o_cntrl_ts_last = ts_last;
    assign c1              = c1_q;
    assign c2              = c2_q;

endmodule

// File: tb/tb_dpwm_prog.sv
module tb_dpwm_prog;

    localparam int CW = 12;
    localparam int DW = 4;
    localparam int MIN_TS = 2;

    logic          i_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          i_load = 1'b0;
    logic [CW-1:0] i_ts = '0;
    logic [CW-1:0] i_ton = '0;
    logic [DW-1:0] i_dt1 = '0;
    logic [DW-1:0] i_dt2 = '0;
    logic [CW-1:0] o_count;
    logic          o_cntrl_ts_last;
    logic          o_pending;
    logic          o_clamped;
    logic          c1;
    logic          c2;

    int checks = 0;
    int errors = 0;

    dpwm_prog dut (
        .i_clk           (i_clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .i_load          (i_load),
        .i_ts            (i_ts),
        .i_ton           (i_ton),
        .i_dt1           (i_dt1),
        .i_dt2           (i_dt2),
        .o_count         (o_count),
        .o_cntrl_ts_last (o_cntrl_ts_last),
        .o_pending       (o_pending),
        .o_clamped       (o_clamped),
        .c1              (c1),
        .c2              (c2)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model (integer arithmetic) ----------------
    int m_cnt, m_ts, m_ton, m_dt1, m_dt2, m_clmp, m_en, m_c1, m_c2;
    int p_vld, p_ts, p_ton, p_dt1, p_dt2;

    task automatic model_reset();
        m_cnt = 0; m_ts = 140; m_ton = 80; m_dt1 = 14; m_dt2 = 10;
        m_clmp = 0; m_en = 0; m_c1 = 0; m_c2 = 0;
        p_vld = 0; p_ts = 0; p_ton = 0; p_dt1 = 0; p_dt2 = 0;
    endtask

    task automatic model_apply(input int ts, input int ton, input int d1, input int d2);
        int t;
        int n;
        t = (ts < MIN_TS) ? MIN_TS : ts;
        n = ton;
        if (d1 + ton + d2 > t) n = (t - d1 - d2 < 0) ? 0 : t - d1 - d2;
        m_clmp = ((t != ts) || (n != ton)) ? 1 : 0;
        m_ts = t; m_ton = n; m_dt1 = d1; m_dt2 = d2;
    endtask

    task automatic model_step();
        int last;
        int gate;
        last = (m_cnt == m_ts - 1) ? 1 : 0;
        gate = (m_en != 0 || (enable && last != 0)) ? 1 : 0;
        m_en = (enable && (m_en != 0 || last != 0)) ? 1 : 0;
        if (last != 0) begin
            if (i_load) model_apply(int'(i_ts), int'(i_ton), int'(i_dt1), int'(i_dt2));
            else if (p_vld != 0) model_apply(p_ts, p_ton, p_dt1, p_dt2);
            p_vld = 0;
            m_cnt = 0;
        end else begin
            if (i_load) begin
                p_vld = 1; p_ts = int'(i_ts); p_ton = int'(i_ton);
                p_dt1 = int'(i_dt1); p_dt2 = int'(i_dt2);
            end
            m_cnt++;
        end
        m_c1 = (gate != 0 && m_cnt >= m_dt1 && m_cnt < m_dt1 + m_ton) ? 1 : 0;
        m_c2 = (gate != 0 && m_cnt >= m_dt1 + m_ton + m_dt2 && m_cnt < m_ts) ? 1 : 0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [16:0] a;
        logic [16:0] e;
        a = {o_count, o_cntrl_ts_last, o_pending, o_clamped, c1, c2};
        e = {CW'(m_cnt), (m_cnt == m_ts - 1), (p_vld != 0), (m_clmp != 0),
             (m_c1 != 0), (m_c2 != 0)};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle t=%0t {cnt,last,pend,clmp,c1,c2}: got %h, expected %h",
                     $time, a, e);
        end
        chk("overlap", int'(c1 & c2), 0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_all();
    endtask

    task automatic load(input int ts, input int ton, input int d1, input int d2);
        i_ts = CW'(ts); i_ton = CW'(ton); i_dt1 = DW'(d1); i_dt2 = DW'(d2);
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    task automatic wait_count(input int n);
        for (int k = 0; k < 5000 && int'(o_count) != n; k++) tick();
        chk("wait_count", int'(o_count), n);
    endtask

    task automatic wait_last();
        for (int k = 0; k < 5000 && !o_cntrl_ts_last; k++) tick();
        chk("wait_last", int'(o_cntrl_ts_last), 1);
    endtask

    // Called at count 0: runs one period and tallies gate activity.
    task automatic measure(output int len, output int c1n, output int c1f,
                           output int c2n, output int c2f);
        len = 0; c1n = 0; c2n = 0; c1f = -1; c2f = -1;
        do begin
            if (c1) begin c1n++; if (c1f < 0) c1f = len; end
            if (c2) begin c2n++; if (c2f < 0) c2f = len; end
            len++;
            tick();
        end while (o_count != '0 && len < 5000);
    endtask

    typedef struct {
        int ts, ton, dt1, dt2;
        int e_ts, e_ton, e_clmp, e_c2n;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int len, c1n, c1f, c2n, c2f;

        vecs[0] = '{100, 50, 14, 10, 100, 50, 0, 26};
        vecs[1] = '{ 50, 40, 14, 10,  50, 26, 1,  0};
        vecs[2] = '{  1,  0, 14, 10,   2,  0, 1,  0};
        vecs[3] = '{ 60, 30, 14, 10,  60, 30, 0,  6};
        vecs[4] = '{ 20, 30, 15, 15,  20,  0, 1,  0};
        vecs[5] = '{  0,  5,  1,  0,   2,  1, 1,  0};
        vecs[6] = '{ 30, 10,  5, 15,  30, 10, 0,  0};
        vecs[7] = '{ 30, 11,  5, 15,  30, 10, 1,  0};
        vecs[8] = '{300,250, 15, 15, 300,250, 0, 20};
        vecs[9] = '{140, 80, 14, 10, 140, 80, 0, 36};

        // Reset state, enable held high from reset.
        model_reset();
        enable = 1'b1;
        @(negedge i_clk);
        check_all();
        @(negedge i_clk);
        reset_n = 1'b1;

        // First period: en_q waits for the boundary, so no pulses.
        measure(len, c1n, c1f, c2n, c2f);
        chk("p0_len", len, 140);
        chk("p0_c1n", c1n, 0);
        // Default pattern.
        measure(len, c1n, c1f, c2n, c2f);
        chk("def_len", len, 140);
        chk("def_c1n", c1n, 80);
        chk("def_c1f", c1f, 14);
        chk("def_c2n", c2n, 36);
        chk("def_c2f", c2f, 104);

        // Mid-period load: deferred to the boundary.
        wait_count(60);
        load(100, 50, 14, 10);
        chk("pend_set", int'(o_pending), 1);
        wait_count(139);
        chk("pend_hold", int'(o_pending), 1);
        tick();
        chk("pend_clr", int'(o_pending), 0);
        measure(len, c1n, c1f, c2n, c2f);
        chk("ld_len", len, 100);
        chk("ld_c1n", c1n, 50);
        chk("ld_c1f", c1f, 14);
        chk("ld_c2n", c2n, 26);
        chk("ld_c2f", c2f, 74);

        // Last-wins on double load.
        wait_count(10);
        load(80, 20, 3, 3);
        load(90, 30, 4, 4);
        wait_last();
        tick();
        measure(len, c1n, c1f, c2n, c2f);
        chk("dbl_len", len, 90);
        chk("dbl_c1f", c1f, 4);

        // Table: loads on the last cycle (bypass) with clamping.
        for (int v = 0; v < 10; v++) begin
            wait_last();
            load(vecs[v].ts, vecs[v].ton, vecs[v].dt1, vecs[v].dt2);
            chk($sformatf("v%0d_pend", v), int'(o_pending), 0);
            chk($sformatf("v%0d_clmp", v), int'(o_clamped), vecs[v].e_clmp);
            measure(len, c1n, c1f, c2n, c2f);
            chk($sformatf("v%0d_len", v), len, vecs[v].e_ts);
            chk($sformatf("v%0d_c1n", v), c1n, vecs[v].e_ton);
            chk($sformatf("v%0d_c2n", v), c2n, vecs[v].e_c2n);
        end

        // Enable drop at count 50, raise at 70 (defaults active now).
        wait_count(50);
        chk("en_c1_50", int'(c1), 1);
        enable = 1'b0;
        tick();
        chk("en_c1_51", int'(c1), 1);
        tick();
        chk("en_c1_52", int'(c1), 0);
        wait_count(70);
        enable = 1'b1;
        wait_count(0);
        chk("en_c1_0", int'(c1), 0);
        wait_count(13);
        chk("en_c1_13", int'(c1), 0);
        tick();
        chk("en_c1_14", int'(c1), 1);

        // Randomised loads and enable changes.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) begin
                i_ts = CW'($urandom_range(0, 70));
                i_ton = CW'($urandom_range(0, 80));
                i_dt1 = DW'($urandom_range(0, 15));
                i_dt2 = DW'($urandom_range(0, 15));
                i_load = 1'b1;
            end
            tick();
            i_load = 1'b0;
        end

        // Asynchronous reset in the middle of a c1 pulse.
        enable = 1'b1;
        wait_last();
        load(140, 80, 14, 10);
        measure(len, c1n, c1f, c2n, c2f);
        wait_count(30);
        chk("rst_c1_pre", int'(c1), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_c1", int'(c1), 0);
        chk("rst_cnt", int'(o_count), 0);
        chk("rst_pend", int'(o_pending), 0);
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        reset_n = 1'b1;
        check_all();
        measure(len, c1n, c1f, c2n, c2f);
        chk("rst_p0_len", len, 140);
        chk("rst_p0_c1n", c1n, 0);
        measure(len, c1n, c1f, c2n, c2f);
        chk("rst_p1_c1n", c1n, 80);
        chk("rst_p1_c1f", c1f, 14);
        chk("rst_p1_c2f", c2f, 104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpwm_prog.md
Name: dpwm_prog

Overview:
Parametrised, run-time programmable successor to the fixed-constant DPWM for the half-bridge power stage. Period, on-time and both dead times come from the control loop through a load strobe. They are double-buffered and applied only at period boundaries, and clamped so the complementary gates can never overlap. Outputs are registered and glitch-free. Enable is gated so the block cannot emit partial pulses on turn-on.

Parameters:
CNT_W, 12, counter, period and on-time width
DT_W, 4, dead-time field width
DEF_TS, 140, period value loaded at reset (clocks)
DEF_TON, 80, on-time loaded at reset
DEF_DT1, 14, leading dead time loaded at reset
DEF_DT2, 10, trailing dead time loaded at reset
MIN_TS, 2, smallest legal period; smaller requests are raised to this

Ports:
i_clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  output enable (level)
i_load  in  1  one-cycle strobe; captures i_ts/i_ton/i_dt1/i_dt2
i_ts  in  CNT_W  requested period
i_ton  in  CNT_W  requested c1 on-time
i_dt1  in  DT_W  dead time before c1
i_dt2  in  DT_W  dead time after c1, before c2
o_count  out  CNT_W  current counter value (ADC trigger use)
o_cntrl_ts_last  out  1  high while count == ts_a-1
o_pending  out  1  loaded set waiting for boundary
o_clamped  out  1  active set was clamped this period
c1  out  1  high-side gate
c2  out  1  low-side gate

Behaviour:
- Reset (async, reset_n=0):
  - count=0
  - active set {ts_a,ton_a,dt1_a,dt2_a} = defaults
  - pending regs cleared
  - c1=c2=0, o_pending=0, o_clamped=0, en_q=0
- Counter runs whenever out of reset, independent of enable.
  - count: 0..ts_a-1, wraps to 0.
  - o_cntrl_ts_last = (count==ts_a-1), combinational from the count register.
- Decode is on count; c1, c2 and count are all registered from next_count, so outputs align with o_count:
  - c1 = en_q & (dt1_a <= count < dt1_a+ton_a)
  - c2 = en_q & (count >= dt1_a+ton_a+dt2_a) & (count < ts_a)
  - Period wrap: c2 drops at wrap; c1 stays low for dt1_a clocks.
- Arithmetic: sums formed at CNT_W+2 bits; no wrap-around.
- Load, i_load=1 on any non-last cycle:
  - inputs go to pending regs; o_pending=1 from the next cycle.
  - A second load before the boundary overwrites pending (last wins).
- Boundary (count==ts_a-1):
  - if pending, copy it into the active set, clamped; o_pending clears.
  - new values govern the period beginning at the next count=0.
- Load on the last cycle: inputs bypass pending and become active for the immediately following period; o_pending stays 0.
- Clamp, applied at the copy:
  - ts = max(i_ts, MIN_TS)
  - if dt1+ton+dt2 > ts, then ton = ts-dt1-dt2, saturating at 0
  - o_clamped=1 for the whole period when any field was altered, else 0
- Enable:
  - falling edge: en_q=0 in the next cycle; c1/c2 low the cycle after enable is sampled low (immediate safe-off).
  - rising edge: en_q sets only at the boundary (count wraps to 0), so the first pulse is a full period.
- Simultaneous enable rise and load at the boundary: both take effect together at count=0.

Decomposition:
- Package dpwm_pkg:
  - CNT_W, DT_W, DEF_* and MIN_TS defaults
  - packed struct dpwm_cfg_t {ts, ton, dt1, dt2}
- Sub-module dpwm_cfg_shadow holds the pending and active registers, bypass and clamp. It outputs the active dpwm_cfg_t plus o_pending/o_clamped.
- Top-level holds the counter, enable gating and output decode.

Test Plan:
- Defaults, enable=1 held from reset:
  - per 140-clock period, c1 high for counts 14..93 (80 clk) and c2 high for 104..139 (36 clk)
  - o_cntrl_ts_last at count 139
  - c1&c2 never both 1
- Load ts=100, ton=50 (dt 14/10) at count 60:
  - current period is unchanged to 139; o_pending=1 from count 61 to 139
  - next period: c1 14..63, c2 74..99, wrap at 99
- Load ts=50, ton=40, dt1=14, dt2=10:
  - ton clamped to 26; c1 14..39; c2 never high (count reaches only 49)
  - o_clamped=1 for that period
  - then load ts=1: period becomes 2, o_clamped=1
- Drop enable at count 50 (c1 high): c1=0 from count 52. Raise enable at count 70: outputs stay 0 until count 0, then c1 rises at count 14.
- Load on count 139 (ts=60, ton=30): the period starting next runs 60 clocks (c1 14..43, c2 54..59); o_pending never asserts.
- Assert reset_n=0 at count 30 with c1=1:
  - c1/c2/count go 0 asynchronously and the defaults are restored
  - after release, the 140/80/14/10 pattern resumes from count 0 with en_q waiting for the first boundary
